// File: rtl/ram_sweep_engine.sv
// Read-compute-write sweep engine: walks an address range, reads two source RAMs,
// and writes one result per channel back at the same address.
module ram_sweep_engine #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned SPLIT_ADDR = 256
) (
    input  logic              CLOCK_50_I,
    input  logic              RESET_I,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] first_addr_i,
    input  logic [ADDR_W-1:0] last_addr_i,
    input  logic [1:0]        mode0_lo_i,
    input  logic [1:0]        mode0_hi_i,
    input  logic [1:0]        mode1_lo_i,
    input  logic [1:0]        mode1_hi_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data0_i,
    input  logic [DATA_W-1:0] rd_data1_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data0_o,
    output logic [DATA_W-1:0] wr_data1_o,
    output logic              wr_en_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned CNT_W = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic [CNT_W-1:0]  drain_cnt, drain_cnt_nxt;
    logic              issue, latch, flush;

    logic [ADDR_W-1:0] last_q;
    logic [1:0]        m0_lo_q, m0_hi_q, m1_lo_q, m1_hi_q;

    logic [RD_LAT-1:0] pipe_vld;
    logic [ADDR_W-1:0] pipe_addr [RD_LAT];

    logic [ADDR_W-1:0] tail_addr;
    logic              tail_vld, tail_hi;
    logic [1:0]        mode0_sel, mode1_sel;

    // Operation set; |x| is formed in DATA_W+1 bits so the most negative value survives.
    function automatic logic [DATA_W-1:0] calc(input logic [1:0]        mode,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        logic [DATA_W:0]   a_x, b_x, a_m, b_m;
        logic [DATA_W+1:0] m_sum;
        a_x   = {a[DATA_W-1], a};
        b_x   = {b[DATA_W-1], b};
        a_m   = a[DATA_W-1] ? (~a_x + (DATA_W+1)'(1)) : a_x;
        b_m   = b[DATA_W-1] ? (~b_x + (DATA_W+1)'(1)) : b_x;
        m_sum = (DATA_W+2)'(a_m) + (DATA_W+2)'(b_m);
        case (mode)
            2'd0:    calc = DATA_W'(a_x + b_x);
            2'd1:    calc = DATA_W'(a_x - b_x);
            2'd2:    calc = DATA_W'(a_m - b_m);
            default: calc = DATA_W'(m_sum >> 1);
        endcase
    endfunction

    // Next-state and sweep address sequencing.
    always_comb begin
        state_nxt     = state;
        rd_addr_nxt   = rd_addr_o;
        drain_cnt_nxt = drain_cnt;
        issue         = 1'b0;
        latch         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    latch       = 1'b1;
                    rd_addr_nxt = first_addr_i;
                    state_nxt   = S_RUN;
                end
            end
            S_RUN: begin
                issue = 1'b1;
                if (abort_i) begin
                    state_nxt   = S_IDLE;
                    rd_addr_nxt = '0;
                end else if (rd_addr_o == last_q) begin
                    state_nxt     = S_DRAIN;
                    drain_cnt_nxt = '0;
                end else begin
                    rd_addr_nxt = rd_addr_o + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (abort_i) begin
                    state_nxt   = S_IDLE;
                    rd_addr_nxt = '0;
                end else if (drain_cnt == CNT_W'(RD_LAT)) begin
                    state_nxt = S_DONE;
                end else begin
                    drain_cnt_nxt = drain_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_nxt   = S_IDLE;
                rd_addr_nxt = '0;
            end
            default: begin
                state_nxt   = S_IDLE;
                rd_addr_nxt = '0;
            end
        endcase
    end

    assign flush     = abort_i && ((state == S_RUN) || (state == S_DRAIN));
    assign tail_vld  = pipe_vld[RD_LAT-1];
    assign tail_addr = pipe_addr[RD_LAT-1];
    // Region follows the address whose data is arriving, not the current read address.
    assign tail_hi   = ({1'b0, tail_addr} >= (ADDR_W+1)'(SPLIT_ADDR));
    assign mode0_sel = tail_hi ? m0_hi_q : m0_lo_q;
    assign mode1_sel = tail_hi ? m1_hi_q : m1_lo_q;

    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            state     <= S_IDLE;
            rd_addr_o <= '0;
            drain_cnt <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_addr_o <= rd_addr_nxt;
            drain_cnt <= drain_cnt_nxt;
            busy_o    <= (state_nxt != S_IDLE);
            done_o    <= (state_nxt == S_DONE);
        end
    end

    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            last_q  <= '0;
            m0_lo_q <= '0;
            m0_hi_q <= '0;
            m1_lo_q <= '0;
            m1_hi_q <= '0;
        end else if (latch) begin
            last_q  <= last_addr_i;
            m0_lo_q <= mode0_lo_i;
            m0_hi_q <= mode0_hi_i;
            m1_lo_q <= mode1_lo_i;
            m1_hi_q <= mode1_hi_i;
        end
    end

    // Address tags travel alongside the RAM read latency.
    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_addr[i] <= '0;
        end else begin
            if (flush) begin
                pipe_vld <= '0;
            end else begin
                pipe_vld[0] <= issue;
                for (int i = 1; i < RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
            end
            pipe_addr[0] <= rd_addr_o;
            for (int i = 1; i < RD_LAT; i++) pipe_addr[i] <= pipe_addr[i-1];
        end
    end

    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            wr_data0_o <= '0;
            wr_data1_o <= '0;
        end else begin
            wr_en_o <= tail_vld && !flush;
            if (tail_vld && !flush) begin
                wr_addr_o  <= tail_addr;
                wr_data0_o <= calc(mode0_sel, rd_data0_i, rd_data1_i);
                wr_data1_o <= calc(mode1_sel, rd_data0_i, rd_data1_i);
            end
        end
    end

endmodule

// File: tb/tb_ram_sweep_engine.sv
// Directed bench for ram_sweep_engine: RD_LAT=1 and RD_LAT=3 instances against a
// behavioural source-RAM model.
module tb_ram_sweep_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, start3 = 1'b0, abort = 1'b0;
    logic [8:0] first = '0, last = '0;
    logic [1:0] m0lo = '0, m0hi = '0, m1lo = '0, m1hi = '0;

    logic [8:0] rd_addr, wr_addr, rd_addr3, wr_addr3;
    logic [7:0] rd_d0, rd_d1, wr_d0, wr_d1;
    logic [7:0] rd3_d0, rd3_d1, wr3_d0, wr3_d1;
    logic       wr_en, busy, done, wr_en3, busy3, done3;
    logic [7:0] p1a, p1b, p2a, p2b;

    logic [7:0] mem_a [512];
    logic [7:0] mem_b [512];

    int n_cmp = 0;
    int n_err = 0;

    initial forever #5 clk = ~clk;

    ram_sweep_engine #(.DATA_W(8), .ADDR_W(9), .RD_LAT(1), .SPLIT_ADDR(256)) dut (
        .CLOCK_50_I(clk), .RESET_I(rst), .start_i(start), .abort_i(abort),
        .first_addr_i(first), .last_addr_i(last),
        .mode0_lo_i(m0lo), .mode0_hi_i(m0hi), .mode1_lo_i(m1lo), .mode1_hi_i(m1hi),
        .rd_addr_o(rd_addr), .rd_data0_i(rd_d0), .rd_data1_i(rd_d1),
        .wr_addr_o(wr_addr), .wr_data0_o(wr_d0), .wr_data1_o(wr_d1),
        .wr_en_o(wr_en), .busy_o(busy), .done_o(done));

    ram_sweep_engine #(.DATA_W(8), .ADDR_W(9), .RD_LAT(3), .SPLIT_ADDR(256)) dut3 (
        .CLOCK_50_I(clk), .RESET_I(rst), .start_i(start3), .abort_i(1'b0),
        .first_addr_i(first), .last_addr_i(last),
        .mode0_lo_i(m0lo), .mode0_hi_i(m0hi), .mode1_lo_i(m1lo), .mode1_hi_i(m1hi),
        .rd_addr_o(rd_addr3), .rd_data0_i(rd3_d0), .rd_data1_i(rd3_d1),
        .wr_addr_o(wr_addr3), .wr_data0_o(wr3_d0), .wr_data1_o(wr3_d1),
        .wr_en_o(wr_en3), .busy_o(busy3), .done_o(done3));

    // Source RAMs: one-cycle q for dut, three-cycle q for dut3.
    always @(posedge clk) begin
        rd_d0  <= mem_a[rd_addr];
        rd_d1  <= mem_b[rd_addr];
        p1a    <= mem_a[rd_addr3];
        p1b    <= mem_b[rd_addr3];
        p2a    <= p1a;
        p2b    <= p1b;
        rd3_d0 <= p2a;
        rd3_d1 <= p2b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [8:0] a,
                          input logic [7:0] d0, input logic [7:0] d1);
        chk_b({tag, ".en"}, wr_en, 1'b1);
        chk_a({tag, ".addr"}, wr_addr, a);
        chk_d({tag, ".ch0"}, wr_d0, d0);
        chk_d({tag, ".ch1"}, wr_d1, d1);
    endtask

    task automatic go(input logic [8:0] f, input logic [8:0] l);
        first = f;
        last  = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        #1;
        chk_a("rst.rd_addr", rd_addr, 9'd0);
        chk_a("rst.wr_addr", wr_addr, 9'd0);
        chk_d("rst.wr_d0", wr_d0, 8'h00);
        chk_d("rst.wr_d1", wr_d1, 8'h00);
        chk_b("rst.wr_en", wr_en, 1'b0);
        chk_b("rst.busy", busy, 1'b0);
        chk_b("rst.done", done, 1'b0);
        chk_b("rst.busy3", busy3, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Basic add/sub sweep 0..3
        mem_a[0] = 8'h7F; mem_b[0] = 8'h01;
        mem_a[1] = 8'h05; mem_b[1] = 8'h03;
        mem_a[2] = 8'h80; mem_b[2] = 8'h01;
        mem_a[3] = 8'hFF; mem_b[3] = 8'hFF;
        m0lo = 2'd0; m1lo = 2'd1; m0hi = 2'd0; m1hi = 2'd0;
        go(9'd0, 9'd3);
        chk_b("t1.busy0", busy, 1'b1);
        chk_a("t1.rd_addr0", rd_addr, 9'd0);
        chk_b("t1.wr_en0", wr_en, 1'b0);
        tick();
        chk_b("t1.wr_en1", wr_en, 1'b0);
        tick(); chk_wr("t1.w0", 9'd0, 8'h80, 8'h7E);
        tick(); chk_wr("t1.w1", 9'd1, 8'h08, 8'h02);
        tick(); chk_wr("t1.w2", 9'd2, 8'h81, 8'h7F);
        tick(); chk_wr("t1.w3", 9'd3, 8'hFE, 8'h00);
        tick();
        chk_b("t1.wr_en6", wr_en, 1'b0);
        chk_b("t1.done6", done, 1'b1);
        chk_b("t1.busy6", busy, 1'b1);
        tick();
        chk_b("t1.done7", done, 1'b0);
        chk_b("t1.busy7", busy, 1'b0);
        chk_a("t1.rd_addr7", rd_addr, 9'd0);

        // Magnitude modes across the split
        for (int i = 254; i <= 257; i++) begin
            mem_a[i] = 8'hF6;
            mem_b[i] = 8'h03;
        end
        m0lo = 2'd0; m0hi = 2'd0; m1lo = 2'd2; m1hi = 2'd3;
        go(9'd254, 9'd257);
        tick();
        tick(); chk_wr("t2.w254", 9'd254, 8'hF9, 8'h07);
        tick(); chk_wr("t2.w255", 9'd255, 8'hF9, 8'h07);
        tick(); chk_wr("t2.w256", 9'd256, 8'hF9, 8'h06);
        tick(); chk_wr("t2.w257", 9'd257, 8'hF9, 8'h06);
        tick();
        chk_b("t2.done", done, 1'b1);
        tick();

        // Mode 3 with both operands at the most negative value
        mem_a[300] = 8'h80; mem_b[300] = 8'h80;
        m0hi = 2'd3; m1hi = 2'd2;
        go(9'd300, 9'd300);
        tick();
        tick(); chk_wr("t2b.w300", 9'd300, 8'h80, 8'h00);
        tick();
        chk_b("t2b.done", done, 1'b1);
        chk_b("t2b.wr_en", wr_en, 1'b0);
        tick();

        // Wrap through the top of the address space, with an ignored start pulse
        mem_a[510] = 8'h01; mem_b[510] = 8'h00;
        mem_a[511] = 8'h02; mem_b[511] = 8'h00;
        mem_a[0]   = 8'h03; mem_b[0]   = 8'h00;
        mem_a[1]   = 8'h04; mem_b[1]   = 8'h00;
        m0lo = 2'd0; m0hi = 2'd0; m1lo = 2'd0; m1hi = 2'd1;
        go(9'd510, 9'd1);
        tick();
        tick(); chk_wr("t3.w510", 9'd510, 8'h01, 8'h01);
        first = 9'd100; last = 9'd100; start = 1'b1;
        tick(); chk_wr("t3.w511", 9'd511, 8'h02, 8'h02);
        start = 1'b0;
        tick(); chk_wr("t3.w0", 9'd0, 8'h03, 8'h03);
        tick(); chk_wr("t3.w1", 9'd1, 8'h04, 8'h04);
        tick();
        chk_b("t3.done", done, 1'b1);
        chk_b("t3.wr_en6", wr_en, 1'b0);
        chk_b("t3.busy6", busy, 1'b1);
        tick();
        chk_b("t3.busy7", busy, 1'b0);
        tick();
        chk_b("t3.busy8", busy, 1'b0);
        chk_b("t3.wr_en8", wr_en, 1'b0);
        chk_a("t3.rd_addr8", rd_addr, 9'd0);

        // Abort in the middle of a full-range sweep
        mem_a[8] = 8'h11; mem_b[8] = 8'h22;
        m0lo = 2'd0; m1lo = 2'd1;
        go(9'd0, 9'd511);
        for (int k = 1; k <= 10; k++) tick();
        chk_wr("t4.w8", 9'd8, 8'h33, 8'hEF);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_b("t4.wr_en11", wr_en, 1'b0);
        chk_b("t4.busy11", busy, 1'b0);
        chk_b("t4.done11", done, 1'b0);
        chk_a("t4.wr_addr11", wr_addr, 9'd8);
        tick();
        chk_b("t4.wr_en12", wr_en, 1'b0);
        chk_b("t4.done12", done, 1'b0);

        // Start with abort held in IDLE does not launch
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_b("t5.busy0", busy, 1'b0);
        tick();
        chk_b("t5.busy1", busy, 1'b0);
        chk_b("t5.wr_en1", wr_en, 1'b0);

        // Asynchronous reset mid-sweep
        go(9'd0, 9'd511);
        for (int k = 1; k <= 4; k++) tick();
        chk_b("t6.wr_en_pre", wr_en, 1'b1);
        rst = 1'b1;
        #1;
        chk_a("t6.rd_addr", rd_addr, 9'd0);
        chk_a("t6.wr_addr", wr_addr, 9'd0);
        chk_d("t6.wr_d0", wr_d0, 8'h00);
        chk_d("t6.wr_d1", wr_d1, 8'h00);
        chk_b("t6.wr_en", wr_en, 1'b0);
        chk_b("t6.busy", busy, 1'b0);
        chk_b("t6.done", done, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk_b("t6.wr_en_post", wr_en, 1'b0);
        chk_b("t6.busy_post", busy, 1'b0);
        tick();
        chk_b("t6.wr_en_post2", wr_en, 1'b0);

        // RD_LAT=3 single-word sweep
        mem_a[5] = 8'h10; mem_b[5] = 8'h20;
        m0lo = 2'd0; m1lo = 2'd1;
        first = 9'd5; last = 9'd5; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk_b("t7.busy0", busy3, 1'b1);
        chk_a("t7.rd_addr0", rd_addr3, 9'd5);
        tick(); tick(); tick();
        chk_b("t7.wr_en3", wr_en3, 1'b0);
        tick();
        chk_b("t7.wr_en4", wr_en3, 1'b1);
        chk_a("t7.wr_addr4", wr_addr3, 9'd5);
        chk_d("t7.ch0", wr3_d0, 8'h30);
        chk_d("t7.ch1", wr3_d1, 8'hF0);
        chk_b("t7.done4", done3, 1'b0);
        tick();
        chk_b("t7.done5", done3, 1'b1);
        chk_b("t7.wr_en5", wr_en3, 1'b0);
        tick();
        chk_b("t7.busy6", busy3, 1'b0);
        chk_b("t7.done6", done3, 1'b0);
        chk_b("t7.dut_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
